commit_queue: RTL and testbench

COMMIT_QUEUE -- requirements
Module: commit_queue

---
 rtl/commit_queue.sv | 176 +++++++++++++++++
 tb/tb_commit_queue.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/commit_queue.sv
// commit_queue: in-order commit buffer between issue and commit.
//
// Instructions are enqueued at the tail. Each slot is identified by its index, the trans_id.
// Writebacks mark a slot done and store its result or exception. The oldest
// NR_COMMIT_PORTS entries are presented to commit. Valid entries form a contiguous run of
// done slots starting at the head.
//
// Ports:
//   clk_i, rst_i       clock (rising edge) and asynchronous active-high reset
//   flush_i            discard every entry (wins over issue, writeback and ack)
//   issue_valid_i/issue_instr_i/issue_ready_o/issue_trans_id_o   enqueue handshake
//   wb_valid_i/wb_trans_id_i/wbdata_i/wb_ex_i                   per-port writeback
//   commit_instr_o     head entries, oldest at index 0
//   commit_ack_i       per-port commit acknowledge (must be contiguous from port 0)

package commit_queue_pkg;

  typedef struct packed {
    logic [63:0] cause;
    logic [63:0] tval;
    logic        valid;
  } exception_t;

  typedef struct packed {
    logic [63:0] pc;
    logic [7:0]  op;
    logic [4:0]  rd;
    logic [63:0] result;
    logic        valid;
    exception_t  ex;
  } scoreboard_entry_t;

endpackage

module commit_queue
  import commit_queue_pkg::*;
#(
  parameter int unsigned NR_ENTRIES      = 8,
  parameter int unsigned NR_COMMIT_PORTS = 2,
  parameter int unsigned NR_WB_PORTS     = 4,
  localparam int unsigned TRANS_ID_BITS  = $clog2(NR_ENTRIES)
) (
  input  logic                                         clk_i,
  input  logic                                         rst_i,
  input  logic                                         flush_i,
  input  logic                                         issue_valid_i,
  input  scoreboard_entry_t                            issue_instr_i,
  output logic                                         issue_ready_o,
  output logic [TRANS_ID_BITS-1:0]                     issue_trans_id_o,
  input  logic [NR_WB_PORTS-1:0]                       wb_valid_i,
  input  logic [NR_WB_PORTS-1:0][TRANS_ID_BITS-1:0]    wb_trans_id_i,
  input  logic [NR_WB_PORTS-1:0][63:0]                 wbdata_i,
  input  exception_t [NR_WB_PORTS-1:0]                 wb_ex_i,
  output scoreboard_entry_t [NR_COMMIT_PORTS-1:0]      commit_instr_o,
  input  logic [NR_COMMIT_PORTS-1:0]                   commit_ack_i
);

  localparam int unsigned CNT_W = TRANS_ID_BITS + 1;

  logic [NR_ENTRIES-1:0]    occupied_q, occupied_d;
  logic [NR_ENTRIES-1:0]    done_q, done_d;
  scoreboard_entry_t        mem_q [NR_ENTRIES];
  scoreboard_entry_t        mem_d [NR_ENTRIES];
  logic [TRANS_ID_BITS-1:0] head_q, head_d;
  logic [TRANS_ID_BITS-1:0] tail_q, tail_d;
  logic [CNT_W-1:0]         count_q, count_d;

  logic [NR_COMMIT_PORTS-1:0] commit_valid;
  logic [CNT_W-1:0]           pop_cnt;
  logic                       issue_fire;

  // Registered count only: a pop in the same cycle does not make room early.
  assign issue_ready_o    = (count_q < CNT_W'(NR_ENTRIES));
  assign issue_trans_id_o = tail_q;
  assign issue_fire       = issue_valid_i & issue_ready_o;

  for (genvar i = 0; i < NR_COMMIT_PORTS; i++) begin : g_commit
    logic [TRANS_ID_BITS-1:0] idx;
    assign idx = head_q + TRANS_ID_BITS'(i);
    if (i == 0) begin : g_first
      assign commit_valid[i] = occupied_q[idx] & done_q[idx];
    end else begin : g_rest
      assign commit_valid[i] = occupied_q[idx] & done_q[idx] & commit_valid[i-1];
    end
    always_comb begin
      commit_instr_o[i]       = mem_q[idx];
      commit_instr_o[i].valid = commit_valid[i];
    end
  end

  // Only the leading run of acked, valid ports is popped.
  always_comb begin
    logic acking;
    pop_cnt = '0;
    acking  = 1'b1;
    for (int unsigned i = 0; i < NR_COMMIT_PORTS; i++) begin
      if (acking && commit_ack_i[i] && commit_valid[i]) begin
        pop_cnt = pop_cnt + CNT_W'(1);
      end else begin
        acking = 1'b0;
      end
    end
  end

  always_comb begin
    logic [TRANS_ID_BITS-1:0] slot;
    occupied_d = occupied_q;
    done_d     = done_q;
    mem_d      = mem_q;
    head_d     = head_q;
    tail_d     = tail_q;
    count_d    = count_q;
    slot       = '0;

    if (flush_i) begin
      occupied_d = '0;
      done_d     = '0;
      head_d     = '0;
      tail_d     = '0;
      count_d    = '0;
    end else begin
      // Ascending port order so the highest qualifying port overrides. Qualification uses
      // registered state, so every port sees the slot as not-done.
      for (int unsigned k = 0; k < NR_WB_PORTS; k++) begin
        slot = wb_trans_id_i[k];
        if (wb_valid_i[k] && occupied_q[slot] && !done_q[slot] &&
            !(issue_fire && (slot == tail_q))) begin
          mem_d[slot].result = wbdata_i[k];
          mem_d[slot].ex     = wb_ex_i[k].valid ? wb_ex_i[k] : mem_q[slot].ex;
          done_d[slot]       = 1'b1;
        end
      end

      for (int unsigned i = 0; i < NR_COMMIT_PORTS; i++) begin
        slot = head_q + TRANS_ID_BITS'(i);
        if (CNT_W'(i) < pop_cnt) begin
          occupied_d[slot] = 1'b0;
          done_d[slot]     = 1'b0;
        end
      end
      head_d = head_q + pop_cnt[TRANS_ID_BITS-1:0];

      // The tail slot is never one being popped: it is free whenever an issue can fire.
      if (issue_fire) begin
        mem_d[tail_q]       = issue_instr_i;
        mem_d[tail_q].valid = 1'b0;
        occupied_d[tail_q]  = 1'b1;
        done_d[tail_q]      = issue_instr_i.ex.valid;
        tail_d              = tail_q + TRANS_ID_BITS'(1);
      end

      count_d = count_q + CNT_W'(issue_fire) - pop_cnt;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      occupied_q <= '0;
      done_q     <= '0;
      head_q     <= '0;
      tail_q     <= '0;
      count_q    <= '0;
      for (int unsigned i = 0; i < NR_ENTRIES; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      occupied_q <= occupied_d;
      done_q     <= done_d;
      head_q     <= head_d;
      tail_q     <= tail_d;
      count_q    <= count_d;
      mem_q      <= mem_d;
    end
  end

endmodule

// File: tb/tb_commit_queue.sv
// Randomized bench for commit_queue against a queue-based reference model, plus directed
// scenarios for wrap, full, ack gating, flush priority and issue-time exceptions.
module tb_commit_queue;
  import commit_queue_pkg::*;

  localparam int N  = 8;
  localparam int CP = 2;
  localparam int WP = 4;

  logic clk = 1'b0;
  logic rst;
  logic flush;
  logic issue_valid;
  scoreboard_entry_t issue_instr;
  logic issue_ready;
  logic [2:0] issue_trans_id;
  logic [WP-1:0] wb_valid;
  logic [WP-1:0][2:0] wb_id;
  logic [WP-1:0][63:0] wbdata;
  exception_t [WP-1:0] wb_ex;
  scoreboard_entry_t [CP-1:0] commit_instr;
  logic [CP-1:0] ack;

  always #5 clk = ~clk;

  commit_queue #(
    .NR_ENTRIES     (N),
    .NR_COMMIT_PORTS(CP),
    .NR_WB_PORTS    (WP)
  ) dut (
    .clk_i           (clk),
    .rst_i           (rst),
    .flush_i         (flush),
    .issue_valid_i   (issue_valid),
    .issue_instr_i   (issue_instr),
    .issue_ready_o   (issue_ready),
    .issue_trans_id_o(issue_trans_id),
    .wb_valid_i      (wb_valid),
    .wb_trans_id_i   (wb_id),
    .wbdata_i        (wbdata),
    .wb_ex_i         (wb_ex),
    .commit_instr_o  (commit_instr),
    .commit_ack_i    (ack)
  );

  // Reference model: in-flight instructions in program order.
  typedef struct {
    int                id;
    bit                done;
    scoreboard_entry_t e;
  } ment_t;

  ment_t mq[$];
  int    next_id;
  int    n_total = 0;
  int    n_bad   = 0;

  task automatic check(input string tag, input logic [319:0] obs, input logic [319:0] exp);
    n_total++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic scoreboard_entry_t mk_instr(input bit exv);
    scoreboard_entry_t s;
    s.pc       = {$urandom, $urandom};
    s.op       = 8'($urandom);
    s.rd       = 5'($urandom);
    s.result   = {$urandom, $urandom};
    s.valid    = 1'($urandom);
    s.ex.cause = 64'($urandom_range(15));
    s.ex.tval  = {$urandom, $urandom};
    s.ex.valid = exv;
    return s;
  endfunction

  task automatic idle();
    flush       = 1'b0;
    issue_valid = 1'b0;
    issue_instr = '0;
    wb_valid    = '0;
    wb_id       = '0;
    wbdata      = '0;
    wb_ex       = '0;
    ack         = '0;
  endtask

  // Compare registered-state outputs with the model, advance the model with the
  // inputs currently driven, then move to the next falling edge.
  task automatic step();
    bit ev[CP];
    bit fire;
    int p;
    int best;
    scoreboard_entry_t x;
    check("ready", issue_ready, mq.size() < N);
    check("trans_id", issue_trans_id, next_id);
    for (int i = 0; i < CP; i++) begin
      ev[i] = (i < mq.size()) && mq[i].done && (i == 0 || ev[i-1]);
      check($sformatf("valid%0d", i), commit_instr[i].valid, ev[i]);
      if (ev[i]) begin
        x       = mq[i].e;
        x.valid = 1'b1;
        check($sformatf("entry%0d", i), commit_instr[i], x);
      end
    end

    if (flush) begin
      mq.delete();
      next_id = 0;
    end else begin
      fire = issue_valid && (mq.size() < N);
      foreach (mq[j]) begin
        if (!mq[j].done && !(fire && mq[j].id == next_id)) begin
          best = -1;
          for (int k = 0; k < WP; k++) begin
            if (wb_valid[k] && int'(wb_id[k]) == mq[j].id) best = k;
          end
          if (best >= 0) begin
            mq[j].e.result = wbdata[best];
            if (wb_ex[best].valid) mq[j].e.ex = wb_ex[best];
            mq[j].done = 1;
          end
        end
      end
      p = 0;
      while (p < CP && ack[p] && ev[p]) p++;
      repeat (p) void'(mq.pop_front());
      if (fire) begin
        x       = issue_instr;
        x.valid = 1'b0;
        mq.push_back('{id: next_id, done: issue_instr.ex.valid, e: x});
        next_id = (next_id + 1) % N;
      end
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_flush();
    idle();
    flush = 1'b1;
    step();
    idle();
  endtask

  initial begin
    idle();
    next_id = 0;
    rst     = 1'b1;
    #1;
    check("rst_ready", issue_ready, 1'b1);
    check("rst_tid", issue_trans_id, 3'd0);
    check("rst_valid", {commit_instr[1].valid, commit_instr[0].valid}, 2'b00);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;

    // Out-of-order writeback: head only valid after id 0 completes.
    for (int i = 0; i < 3; i++) begin
      issue_valid = 1'b1;
      issue_instr = mk_instr(1'b0);
      step();
    end
    idle();
    wb_valid[2] = 1'b1; wb_id[2] = 3'd1; wbdata[2] = 64'h1111;
    step();
    idle();
    check("ooo_p0_wait", commit_instr[0].valid, 1'b0);
    wb_valid[0] = 1'b1; wb_id[0] = 3'd0; wbdata[0] = 64'h2222;
    step();
    idle();
    check("ooo_p01", {commit_instr[1].valid, commit_instr[0].valid}, 2'b11);
    step();

    // Non-contiguous ack pops nothing; writeback to a free slot is ignored.
    ack = 2'b10;
    wb_valid[1] = 1'b1; wb_id[1] = 3'd5; wbdata[1] = 64'hdead;
    step();
    idle();
    check("ack10_tid", issue_trans_id, 3'd3);
    step();

    // Fill to full, then ack two while issuing: no issue, room again next cycle.
    do_flush();
    for (int i = 0; i < N; i++) begin
      issue_valid = 1'b1;
      issue_instr = mk_instr(1'b1);
      step();
    end
    check("full_ready", issue_ready, 1'b0);
    ack = 2'b11;
    issue_instr = mk_instr(1'b1);
    step();
    idle();
    check("after_pop_ready", issue_ready, 1'b1);
    check("after_pop_tid", issue_trans_id, 3'd0);
    step();

    // Flush wins over simultaneous issue, writeback and ack.
    issue_valid = 1'b1; issue_instr = mk_instr(1'b1);
    wb_valid = 4'b1111; wb_id = {3'd4, 3'd3, 3'd2, 3'd1};
    ack = 2'b11; flush = 1'b1;
    step();
    idle();
    check("flush_tid", issue_trans_id, 3'd0);
    check("flush_valid", {commit_instr[1].valid, commit_instr[0].valid}, 2'b00);
    step();

    // Exception at issue is committable next cycle without writeback.
    issue_valid = 1'b1;
    issue_instr = mk_instr(1'b1);
    issue_instr.ex.cause = 64'd2;
    step();
    idle();
    check("ex_valid", commit_instr[0].valid, 1'b1);
    check("ex_cause", commit_instr[0].ex.cause, 64'd2);
    step();

    // 20 entries streamed through; ids wrap and order is preserved.
    do_flush();
    for (int i = 0; i < 22; i++) begin
      issue_valid = (i < 20);
      issue_instr = mk_instr(1'b1);
      ack         = 2'b11;
      step();
    end
    idle();

    // Random traffic.
    for (int c = 0; c < 3000; c++) begin
      idle();
      flush       = ($urandom_range(59) == 0);
      issue_valid = ($urandom_range(9) < 7);
      issue_instr = mk_instr($urandom_range(15) == 0);
      for (int k = 0; k < WP; k++) begin
        wb_valid[k] = ($urandom_range(3) != 0);
        if (mq.size() > 0 && $urandom_range(4) != 0)
          wb_id[k] = 3'(mq[$urandom_range(mq.size() - 1)].id);
        else
          wb_id[k] = 3'($urandom);
        wbdata[k]      = {$urandom, $urandom};
        wb_ex[k].cause = 64'($urandom_range(15));
        wb_ex[k].tval  = {$urandom, $urandom};
        wb_ex[k].valid = ($urandom_range(7) == 0);
      end
      ack = 2'($urandom);
      if (c == 1500) begin
        idle();
        #2 rst = 1'b1;
        #1;
        check("mid_rst_ready", issue_ready, 1'b1);
        check("mid_rst_tid", issue_trans_id, 3'd0);
        check("mid_rst_valid", {commit_instr[1].valid, commit_instr[0].valid}, 2'b00);
        mq.delete();
        next_id = 0;
        @(negedge clk);
        rst = 1'b0;
      end
      step();
    end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
